// File: rtl/rx_arp_cache.sv
// rtl/rx_arp_cache.sv - ARP receiver with parametrised IP->MAC cache
//
// Purpose : parses ARP frames from the RX byte stream, learns sender
//           bindings into a CACHE_DEPTH-entry cache, triggers the TX ARP
//           block for requests addressed to FPGA_IP and serves one-cycle
//           IP->MAC lookups for the TX UDP/IP path.
// Option  : define ARP_CACHE_AGE_EN to enable entry aging (AGE_TICK, AGE_MAX).
// Ports   : CLK_125M, SYS_RST (async, active-high)
//           RGMII_RX_DATA/VALID/LAST/USER, RGMII_RX_READY - RX byte stream
//           TRIG_TX_ARP, PC_MAC, PC_IP                   - reply trigger
//           LOOKUP_REQ, LOOKUP_IP                        - lookup request
//           LOOKUP_DONE, LOOKUP_HIT, LOOKUP_MAC          - lookup result
//           DROP_CNT                                     - dropped frames

module rx_arp_cache #(
    parameter logic [31:0] FPGA_IP     = 32'hC0A8_006E,
    parameter logic [47:0] FPGA_MAC    = 48'h00_0A_35_01_02_03,
    parameter int          CACHE_DEPTH = 4,
    parameter int          AGE_TICK    = 125_000_000,
    parameter int          AGE_MAX     = 15
) (
    input  logic        CLK_125M,
    input  logic        SYS_RST,
    input  logic [7:0]  RGMII_RX_DATA,
    input  logic        RGMII_RX_VALID,
    input  logic        RGMII_RX_LAST,
    input  logic        RGMII_RX_USER,
    output logic        RGMII_RX_READY,
    output logic        TRIG_TX_ARP,
    output logic [47:0] PC_MAC,
    output logic [31:0] PC_IP,
    input  logic        LOOKUP_REQ,
    input  logic [31:0] LOOKUP_IP,
    output logic        LOOKUP_DONE,
    output logic        LOOKUP_HIT,
    output logic [47:0] LOOKUP_MAC,
    output logic [15:0] DROP_CNT
);

    localparam int PW = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ETH_HDR  = 3'd1,
        ARP_BODY = 3'd2,
        DRAIN    = 3'd3,
        COMMIT   = 3'd4
    } state_t;

    state_t      state;
    logic [5:0]  byte_cnt;      // offset of the beat currently presented
    logic        drop_q;
    logic        user_q;
    logic        da_uc_q;       // DA bytes so far equal FPGA_MAC
    logic        da_bc_q;       // DA bytes so far equal broadcast
    logic        oper_req_q;
    logic [47:0] sha_q;
    logic [31:0] spa_q;
    logic [31:0] tpa_q;

    logic [31:0]            ip_q  [CACHE_DEPTH];
    logic [47:0]            mac_q [CACHE_DEPTH];
    logic [CACHE_DEPTH-1:0] valid_q;
    logic [PW-1:0]          ptr_q;

    logic       beat;
    logic       in_hdr;
    logic [7:0] mac_byte;
    logic       da_uc_n;
    logic       da_bc_n;
    logic       fld_mm;

    // Ready is combinational so it drops the instant reset is asserted.
    assign RGMII_RX_READY = ~SYS_RST;
    assign beat           = RGMII_RX_VALID & RGMII_RX_READY;
    assign in_hdr         = (state == IDLE) || (state == ETH_HDR) || (state == ARP_BODY);

    // Per-byte header check. The DA is accepted only if all six bytes match
    // one of the two addresses, so the two match flags accumulate separately.
    always_comb begin
        mac_byte = 8'h00;
        case (byte_cnt)
            6'd0: mac_byte = FPGA_MAC[47:40];
            6'd1: mac_byte = FPGA_MAC[39:32];
            6'd2: mac_byte = FPGA_MAC[31:24];
            6'd3: mac_byte = FPGA_MAC[23:16];
            6'd4: mac_byte = FPGA_MAC[15:8];
            6'd5: mac_byte = FPGA_MAC[7:0];
            default: mac_byte = 8'h00;
        endcase
        da_uc_n = ((state == IDLE) ? 1'b1 : da_uc_q) & (RGMII_RX_DATA == mac_byte);
        da_bc_n = ((state == IDLE) ? 1'b1 : da_bc_q) & (RGMII_RX_DATA == 8'hFF);
        fld_mm  = 1'b0;
        case (byte_cnt)
            6'd0, 6'd1, 6'd2,
            6'd3, 6'd4, 6'd5: fld_mm = !(da_uc_n || da_bc_n);
            6'd12: fld_mm = (RGMII_RX_DATA != 8'h08);
            6'd13: fld_mm = (RGMII_RX_DATA != 8'h06);
            6'd14: fld_mm = (RGMII_RX_DATA != 8'h00);
            6'd15: fld_mm = (RGMII_RX_DATA != 8'h01);
            6'd16: fld_mm = (RGMII_RX_DATA != 8'h08);
            6'd17: fld_mm = (RGMII_RX_DATA != 8'h00);
            6'd18: fld_mm = (RGMII_RX_DATA != 8'h06);
            6'd19: fld_mm = (RGMII_RX_DATA != 8'h04);
            6'd20: fld_mm = (RGMII_RX_DATA != 8'h00);
            6'd21: fld_mm = (RGMII_RX_DATA != 8'h01) && (RGMII_RX_DATA != 8'h02);
            default: fld_mm = 1'b0;
        endcase
        if (!in_hdr) begin
            fld_mm = 1'b0;
        end
    end

    // Cache match / free-slot search.
    logic [CACHE_DEPTH-1:0] spa_hit;
    logic [CACHE_DEPTH-1:0] lk_hit;
    logic [47:0]            lk_mac;
    logic [PW-1:0]          upd_idx;
    logic [PW-1:0]          free_idx;
    logic                   free_any;

    always_comb begin
        spa_hit  = '0;
        lk_hit   = '0;
        lk_mac   = '0;
        upd_idx  = '0;
        free_idx = '0;
        free_any = 1'b0;
        for (int i = 0; i < CACHE_DEPTH; i++) begin
            spa_hit[i] = valid_q[i] && (ip_q[i] == spa_q);
            lk_hit[i]  = valid_q[i] && (ip_q[i] == LOOKUP_IP);
            if (lk_hit[i]) begin
                lk_mac = lk_mac | mac_q[i];
            end
            if (spa_hit[i]) begin
                upd_idx = PW'(i);
            end
        end
        // Descending scan so the lowest invalid index is the one kept.
        for (int i = CACHE_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_idx = PW'(i);
            end
        end
    end

    logic          frame_bad;
    logic          spa_zero;
    logic          for_us;
    logic          do_upd;
    logic          do_ins;
    logic          wr_en;
    logic          ptr_adv;
    logic [PW-1:0] wr_idx;

    assign frame_bad = drop_q | user_q;
    assign spa_zero  = (spa_q == 32'd0);
    assign for_us    = (tpa_q == FPGA_IP);
    assign do_upd    = !frame_bad && !spa_zero && (|spa_hit);
    assign do_ins    = !frame_bad && !spa_zero && !(|spa_hit) && for_us;
    assign wr_en     = (state == COMMIT) && (do_upd || do_ins);
    assign ptr_adv   = (state == COMMIT) && do_ins && !free_any;
    assign wr_idx    = do_upd ? upd_idx : (free_any ? free_idx : ptr_q);

    // Frame FSM with registered trigger and drop counter.
    always_ff @(posedge CLK_125M or posedge SYS_RST) begin
        if (SYS_RST) begin
            state       <= IDLE;
            byte_cnt    <= 6'd0;
            drop_q      <= 1'b0;
            user_q      <= 1'b0;
            da_uc_q     <= 1'b0;
            da_bc_q     <= 1'b0;
            TRIG_TX_ARP <= 1'b0;
            PC_MAC      <= 48'd0;
            PC_IP       <= 32'd0;
            DROP_CNT    <= 16'd0;
        end else begin
            TRIG_TX_ARP <= 1'b0;
            if (beat && in_hdr) begin
                da_uc_q <= da_uc_n;
                da_bc_q <= da_bc_n;
            end
            case (state)
                IDLE: begin
                    if (beat) begin
                        drop_q <= fld_mm;
                        user_q <= 1'b0;
                        if (RGMII_RX_LAST) begin
                            DROP_CNT <= DROP_CNT + 16'd1;
                        end else begin
                            byte_cnt <= 6'd1;
                            state    <= fld_mm ? DRAIN : ETH_HDR;
                        end
                    end
                end
                ETH_HDR, ARP_BODY: begin
                    if (beat) begin
                        byte_cnt <= (byte_cnt == 6'd63) ? 6'd63 : byte_cnt + 6'd1;
                        drop_q   <= drop_q | fld_mm;
                        if (RGMII_RX_LAST) begin
                            if (state == ARP_BODY && byte_cnt == 6'd41) begin
                                user_q <= RGMII_RX_USER;
                                state  <= COMMIT;
                            end else begin
                                // runt: counted here, never reaches COMMIT
                                DROP_CNT <= DROP_CNT + 16'd1;
                                byte_cnt <= 6'd0;
                                state    <= IDLE;
                            end
                        end else if (fld_mm) begin
                            state <= DRAIN;
                        end else if (state == ETH_HDR && byte_cnt == 6'd13) begin
                            state <= ARP_BODY;
                        end else if (state == ARP_BODY && byte_cnt == 6'd41) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (beat) begin
                        byte_cnt <= (byte_cnt == 6'd63) ? 6'd63 : byte_cnt + 6'd1;
                        if (RGMII_RX_LAST) begin
                            user_q <= RGMII_RX_USER;
                            state  <= COMMIT;
                        end
                    end
                end
                COMMIT: begin
                    byte_cnt <= 6'd0;
                    state    <= IDLE;
                    if (frame_bad) begin
                        DROP_CNT <= DROP_CNT + 16'd1;
                    end else if (for_us && oper_req_q) begin
                        TRIG_TX_ARP <= 1'b1;
                        PC_MAC      <= sha_q;
                        PC_IP       <= spa_q;
                    end
                end
                default: begin
                    byte_cnt <= 6'd0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Field capture; each field is fully shifted in, so no clearing needed.
    always_ff @(posedge CLK_125M or posedge SYS_RST) begin
        if (SYS_RST) begin
            oper_req_q <= 1'b0;
            sha_q      <= 48'd0;
            spa_q      <= 32'd0;
            tpa_q      <= 32'd0;
        end else if (beat && (state == ETH_HDR || state == ARP_BODY)) begin
            if (byte_cnt == 6'd21) begin
                oper_req_q <= (RGMII_RX_DATA == 8'h01);
            end
            if (byte_cnt >= 6'd22 && byte_cnt <= 6'd27) begin
                sha_q <= {sha_q[39:0], RGMII_RX_DATA};
            end
            if (byte_cnt >= 6'd28 && byte_cnt <= 6'd31) begin
                spa_q <= {spa_q[23:0], RGMII_RX_DATA};
            end
            if (byte_cnt >= 6'd38 && byte_cnt <= 6'd41) begin
                tpa_q <= {tpa_q[23:0], RGMII_RX_DATA};
            end
        end
    end

`ifdef ARP_CACHE_AGE_EN
    logic [31:0] pre_q;
    logic        age_tick;
    logic [3:0]  age_q [CACHE_DEPTH];

    assign age_tick = (pre_q == 32'(AGE_TICK - 1));

    always_ff @(posedge CLK_125M or posedge SYS_RST) begin
        if (SYS_RST) begin
            pre_q <= 32'd0;
        end else begin
            pre_q <= age_tick ? 32'd0 : pre_q + 32'd1;
        end
    end
`else
    // Aging parameters are only consumed by the aging build.
    if (AGE_TICK < 1 || AGE_MAX < 1 || AGE_MAX > 15) begin : g_age_cfg_unused
    end
`endif

    // Cache storage. The COMMIT write is placed after the aging update so
    // a coincident write takes precedence over expiry.
    always_ff @(posedge CLK_125M or posedge SYS_RST) begin
        if (SYS_RST) begin
            valid_q <= '0;
            ptr_q   <= '0;
            for (int i = 0; i < CACHE_DEPTH; i++) begin
                ip_q[i]  <= 32'd0;
                mac_q[i] <= 48'd0;
`ifdef ARP_CACHE_AGE_EN
                age_q[i] <= 4'd0;
`endif
            end
        end else begin
`ifdef ARP_CACHE_AGE_EN
            if (age_tick) begin
                for (int i = 0; i < CACHE_DEPTH; i++) begin
                    if (valid_q[i]) begin
                        if ({1'b0, age_q[i]} + 5'd1 >= 5'(AGE_MAX)) begin
                            valid_q[i] <= 1'b0;
                            age_q[i]   <= 4'(AGE_MAX);
                        end else begin
                            age_q[i] <= age_q[i] + 4'd1;
                        end
                    end
                end
            end
`endif
            if (wr_en) begin
                ip_q[wr_idx]    <= spa_q;
                mac_q[wr_idx]   <= sha_q;
                valid_q[wr_idx] <= 1'b1;
`ifdef ARP_CACHE_AGE_EN
                age_q[wr_idx]   <= 4'd0;
`endif
            end
            if (ptr_adv) begin
                ptr_q <= ptr_q + PW'(1);
            end
        end
    end

    // Registered lookup; it compares against pre-commit contents.
    always_ff @(posedge CLK_125M or posedge SYS_RST) begin
        if (SYS_RST) begin
            LOOKUP_DONE <= 1'b0;
            LOOKUP_HIT  <= 1'b0;
            LOOKUP_MAC  <= 48'd0;
        end else begin
            LOOKUP_DONE <= LOOKUP_REQ;
            LOOKUP_HIT  <= LOOKUP_REQ && (|lk_hit);
            LOOKUP_MAC  <= LOOKUP_REQ ? lk_mac : 48'd0;
        end
    end

endmodule

// File: doc/rx_arp_cache.md
Name: rx_arp_cache

Overview:
- Byte-stream ARP receiver with a parametrised N-entry IP->MAC cache. Sits on the AXIS RX path after the RGMII receiver, in parallel with the other RX protocol parsers.
- Filters by Ethernet destination and validates the full ARP header. Handles both request and reply opcodes and learns sender bindings.
- Pulses a reply trigger toward the TX ARP block and serves single-cycle IP->MAC lookups for the TX UDP/IP path.

Parameters:
- FPGA_IP, 32'hC0A8_006E, local IPv4 address.
- FPGA_MAC, 48'h00_0A_35_01_02_03, local MAC; Ethernet DA must equal this or FF:FF:FF:FF:FF:FF.
- CACHE_DEPTH, 4, number of cache entries; power of two, 2..16.
- AGE_TICK, 125_000_000, cycles per age tick (only used with the optional feature).
- AGE_MAX, 15, age ticks until an entry expires (only used with the optional feature; 4-bit).

Ports:
- CLK_125M  in  1  clock; all logic is on the rising edge.
- SYS_RST  in  1  asynchronous reset, active-high.
- RGMII_RX_DATA  in  8  frame byte.
- RGMII_RX_VALID  in  1  byte valid.
- RGMII_RX_LAST  in  1  last byte of frame.
- RGMII_RX_USER  in  1  frame error flag, sampled with LAST.
- RGMII_RX_READY  out  1  0 during reset; 1 at all other times.
- TRIG_TX_ARP  out  1  one-cycle pulse: answer the request addressed to FPGA_IP.
- PC_MAC  out  48  requester MAC; valid when TRIG_TX_ARP is high and held until the next trigger.
- PC_IP  out  32  requester IP; same timing as PC_MAC.
- LOOKUP_REQ  in  1  lookup strobe.
- LOOKUP_IP  in  32  IP to resolve.
- LOOKUP_DONE  out  1  one-cycle pulse, 1 cycle after LOOKUP_REQ.
- LOOKUP_HIT  out  1  valid with LOOKUP_DONE.
- LOOKUP_MAC  out  48  valid with LOOKUP_DONE when LOOKUP_HIT=1; otherwise 0.
- DROP_CNT  out  16  count of dropped frames, wraps.

Behaviour:
- Reset: every output is 0, all cache entries are invalid, the replacement pointer is 0, and the FSM is in IDLE.
- Beats: a beat is VALID & READY. A 6-bit byte counter counts beats and saturates at 63.
- Fields checked, by byte offset:
  - 0-5 DA: FPGA_MAC or broadcast.
  - 12-13 type: 0x0806.
  - 14-15 HTYPE: 0x0001.
  - 16-17 PTYPE: 0x0800.
  - 18 HLEN: 0x06.
  - 19 PLEN: 0x04.
  - 20-21 OPER: must be 1 (request) or 2 (reply).
- Fields captured: 22-27 SHA, 28-31 SPA, 38-41 TPA.
- Any field mismatch sets the drop flag. Bytes 42 and beyond (padding, FCS) are ignored.
- FSM states:
  - IDLE -> ETH_HDR on the first beat, which is counted as byte 0.
  - ETH_HDR -> ARP_BODY after byte 13.
  - ARP_BODY -> DRAIN after byte 41.
  - Any state -> DRAIN on a mismatch when LAST is not present.
  - DRAIN -> COMMIT on a LAST beat.
  - COMMIT -> IDLE unconditionally; COMMIT lasts 1 cycle.
- LAST handling in the header states:
  - LAST arriving in ETH_HDR or ARP_BODY (before byte 41) counts as a runt: drop, go directly to IDLE.
  - LAST on byte 41 itself goes to COMMIT.
- Single-beat frame (VALID and LAST on the first beat) is a drop and the FSM stays in IDLE.
- COMMIT with drop flag set, or USER=1 on the LAST beat: DROP_CNT increments and nothing else changes.
- COMMIT with a clean frame:
  - If SPA matches a valid entry, overwrite its MAC with SHA and reset its age.
  - Else, if TPA == FPGA_IP, insert {SPA,SHA}: use the lowest-index invalid entry; if none is invalid, use the entry at the pointer, then increment the pointer modulo CACHE_DEPTH.
  - If TPA == FPGA_IP and OPER == 1: TRIG_TX_ARP=1 for this cycle, PC_MAC<=SHA, PC_IP<=SPA.
  - A clean frame with TPA != FPGA_IP and no cache match produces no side effects and is not counted as a drop.
- SPA = 0.0.0.0 (probe): the frame never writes the cache; a trigger is still raised if TPA == FPGA_IP.
- Lookup:
  - Compares LOOKUP_IP against all valid entries in parallel; results are registered, giving 1-cycle latency.
  - A lookup in the same cycle as COMMIT sees the pre-commit contents.
  - Back-to-back LOOKUP_REQ is supported at one lookup per cycle.
- Reset asserted mid-frame clears all state immediately. The remainder of the frame after release is treated as a new frame and is dropped as malformed.

Optional Feature:
- Macro: ARP_CACHE_AGE_EN.
- When defined:
  - A prescaler emits a tick every AGE_TICK cycles.
  - Each valid entry's 4-bit age increments on each tick and saturates at AGE_MAX.
  - An entry that reaches AGE_MAX is invalidated on the same tick.
  - A COMMIT write sets that entry's age to 0. If a COMMIT write and a tick coincide for the same entry, the write wins.
- When not defined: entries never expire, and there is no prescaler or age storage.

Test Plan:
- Broadcast request, SPA=C0A80064, SHA=11:22:33:44:55:66, TPA=C0A8006E, 60-byte frame -> after LAST, one TRIG_TX_ARP pulse with PC_IP=C0A80064 and PC_MAC=112233445566; LOOKUP C0A80064 -> HIT with that MAC.
- Reply from C0A80064 with new SHA AA:BB:CC:DD:EE:01 -> no trigger, entry updated; a second reply from unknown C0A80099 to TPA=C0A80001 -> no insert, DROP_CNT unchanged.
- Type 0x0800 frame, then HLEN=0x08 frame, then 30-byte runt, then clean request with USER=1 on LAST -> DROP_CNT=4, no trigger, cache unchanged.
- Five requests to FPGA_IP from distinct IPs .1-.5 with CACHE_DEPTH=4 -> .5 replaces .1; lookup .1 misses, lookup .5 hits.
- LOOKUP_REQ in the COMMIT cycle of a new learn -> miss; the next cycle -> hit. SYS_RST pulsed at byte 20 -> all outputs 0, and the following frame is processed normally.
- With ARP_CACHE_AGE_EN, AGE_TICK=10, AGE_MAX=3: learn an entry, wait 30 cycles -> lookup misses. Refreshing the entry at cycle 25 -> still hits at cycle 40.
